// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit direction counter
// states, BTB write operations and the saturating counter update.
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    typedef enum logic [1:0] {
        WR_NONE   = 2'b00,
        WR_JAL    = 2'b01,
        WR_BRANCH = 2'b10
    } wr_op_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic cnt_e sat_update(input cnt_e cnt, input logic taken);
        logic [1:0] raw;
        raw = cnt;
        if (taken) begin
            return (cnt == ST) ? ST : cnt_e'(raw + 2'd1);
        end
        return (cnt == SNT) ? SNT : cnt_e'(raw - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side bundle between the pipeline (master) and the predictor (slave).
interface branch_predict_unit_if;

    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic [31:0] ex_pc;
    logic        ex_Branch;
    logic        ex_Jump;
    logic        ex_PCspecial;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_predicted_bit;
    logic        ex_stall;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    modport master (
        output if_pc, ex_pc, ex_Branch, ex_Jump, ex_PCspecial, ex_taken,
               ex_target, ex_predicted_bit, ex_stall,
        input  if_pred_taken, if_pred_target, mispredict, redirect_pc,
               br_count, mispred_count
    );

    modport slave (
        input  if_pc, ex_pc, ex_Branch, ex_Jump, ex_PCspecial, ex_taken,
               ex_target, ex_predicted_bit, ex_stall,
        output if_pred_taken, if_pred_target, mispredict, redirect_pc,
               br_count, mispred_count
    );

endinterface

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage: combinational fetch read port, synchronous EX write
// port that applies allocation and counter training to the addressed entry.
module btb_array
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rd_pc_i,
    output logic        rd_hit_o,
    output cnt_e        rd_cnt_o,
    output logic [31:0] rd_target_o,
    input  wr_op_e      wr_op_i,
    input  logic [31:0] wr_pc_i,
    input  logic [31:0] wr_target_i,
    input  logic        wr_taken_i
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    cnt_e             cnt_q    [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             wr_en;
    logic [31:0]      wr_target_d;
    cnt_e             wr_cnt_d;

    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign rd_tag = rd_pc_i[31:IDX_W+2];
    assign wr_idx = wr_pc_i[IDX_W+1:2];
    assign wr_tag = wr_pc_i[31:IDX_W+2];

    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_cnt_o    = cnt_q[rd_idx];
    assign rd_target_o = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        wr_en       = 1'b0;
        wr_target_d = target_q[wr_idx];
        wr_cnt_d    = cnt_q[wr_idx];
        unique case (wr_op_i)
            WR_JAL: begin
                wr_en       = 1'b1;
                wr_target_d = wr_target_i;
                wr_cnt_d    = ST;
            end
            WR_BRANCH: begin
                if (wr_hit) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = sat_update(cnt_q[wr_idx], wr_taken_i);
                    if (wr_taken_i) wr_target_d = wr_target_i;
                end else if (wr_taken_i) begin
                    // Taken miss evicts whatever alias held this index.
                    wr_en       = 1'b1;
                    wr_target_d = wr_target_i;
                    wr_cnt_d    = WT;
                end
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= cnt_e'(CNT_INIT);
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_d;
            cnt_q[wr_idx]    <= wr_cnt_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor top: fetch-time lookup, EX-time resolution and redirect,
// table training and saturating performance counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_predict_unit_if.slave bus
);

    logic        rd_hit;
    cnt_e        rd_cnt;
    logic [31:0] rd_target;
    logic        pred_taken;

    logic        cf;
    logic        act_taken;
    logic        resolve;
    wr_op_e      wr_op;

    logic [31:0] br_count_q;
    logic [31:0] br_count_d;
    logic [31:0] mispred_count_q;
    logic [31:0] mispred_count_d;

    btb_array #(
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc_i     (bus.if_pc),
        .rd_hit_o    (rd_hit),
        .rd_cnt_o    (rd_cnt),
        .rd_target_o (rd_target),
        .wr_op_i     (wr_op),
        .wr_pc_i     (bus.ex_pc),
        .wr_target_i (bus.ex_target),
        .wr_taken_i  (bus.ex_taken)
    );

    assign pred_taken         = rd_hit & rd_cnt[1];
    assign bus.if_pred_taken  = pred_taken;
    assign bus.if_pred_target = pred_taken ? rd_target : bus.if_pc + PC_STEP;

    assign cf        = bus.ex_Branch | bus.ex_Jump | bus.ex_PCspecial;
    assign act_taken = bus.ex_Jump | bus.ex_PCspecial | (bus.ex_Branch & bus.ex_taken);
    assign resolve   = cf & ~bus.ex_stall;

    assign bus.mispredict  = resolve & (act_taken != bus.ex_predicted_bit);
    assign bus.redirect_pc = act_taken ? bus.ex_target : bus.ex_pc + PC_STEP;

    // jalr is never cached: its target is register-dependent, so it always redirects.
    always_comb begin
        wr_op = WR_NONE;
        if (resolve && !bus.ex_PCspecial) begin
            if (bus.ex_Jump)        wr_op = WR_JAL;
            else if (bus.ex_Branch) wr_op = WR_BRANCH;
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve && br_count_q != '1) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (bus.mispredict && mispred_count_q != '1) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign bus.br_count      = br_count_q;
    assign bus.mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Direct-mapped branch target buffer with 2-bit saturating direction counters. It serves the fetch stage with a taken/target prediction for the current PC. It also consumes resolved control-flow information from the execute stage, downstream of the ID/EX pipeline register: `ex_Branch`, `ex_Jump`, `ex_PCspecial`, `ex_predicted_bit`, the PC and the target. From that it flags mispredictions, supplies the redirect PC, trains the table and keeps performance counters.

## Interface
- `IDX_W`, 6: index width; table holds 2^IDX_W entries; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]
- `CNT_INIT`, 2'b01: counter value loaded at reset (weakly not-taken)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `if_pc`  in  32  fetch PC to look up
- `if_pred_taken`  out  1  prediction for if_pc (feeds id_predicted_bit via IF/ID)
- `if_pred_target`  out  32  predicted next PC
- `ex_pc`  in  32  PC of instruction in EX
- `ex_Branch`  in  1  B-type in EX
- `ex_Jump`  in  1  jal in EX
- `ex_PCspecial`  in  1  jalr in EX
- `ex_taken`  in  1  branch comparator outcome (meaningful only with ex_Branch)
- `ex_target`  in  32  computed target address
- `ex_predicted_bit`  in  1  prediction carried with the EX instruction
- `ex_stall`  in  1  EX held this cycle; suppresses resolution, training and stats
- `mispredict`  out  1  flush IF/ID and ID/EX, load redirect_pc
- `redirect_pc`  out  32  corrected fetch PC
- `br_count`  out  32  resolved control-flow instructions
- `mispred_count`  out  32  mispredictions

## Operation
- Entry: valid (1), tag (30-IDX_W), target (32), cnt (2).
- Lookup (combinational): hit = valid[idx] & tag match.
  - if_pred_taken = hit & cnt[1].
  - if_pred_target = if_pred_taken ? target : if_pc + 4.
- Resolution (combinational, qualified by !ex_stall):
  - cf = ex_Branch | ex_Jump | ex_PCspecial.
  - act_taken = ex_Jump | ex_PCspecial | (ex_Branch & ex_taken).
  - mispredict = cf & !ex_stall & (act_taken != ex_predicted_bit).
  - redirect_pc = act_taken ? ex_target : ex_pc + 4, driven regardless of mispredict.
- Training (rising edge, when cf & !ex_stall):
  - jalr: never allocated or updated. It is always mispredicted, because its predicted bit is 0.
  - jal: write valid=1, tag, target, cnt=11.
  - Branch, hit: cnt saturating +1 if taken, −1 if not; target overwritten with ex_target when taken.
  - Branch, miss, taken: allocate with valid=1, tag, target, cnt=10 (replaces any alias).
  - Branch, miss, not taken: no write.
  - Saturation: 11+1 = 11, 00−1 = 00.
- Stats:
  - br_count +1 per resolved cf.
  - mispred_count +1 per mispredict.
  - Both saturate at 0xFFFF_FFFF.
- No FSM beyond per-entry counters; the counter states are SNT=00, WNT=01, WT=10, ST=11.

## Timing
- Reset (async assert, any time, including mid-training): all valid=0, all cnt=CNT_INIT, targets/tags=0, stats=0.
  - Outputs immediately: if_pred_taken=0, if_pred_target=if_pc+4, mispredict=0 unless cf inputs are active.
- Lookup latency 0 cycles; training visible on the lookup the cycle after the edge.
- Same-index read and write in one cycle: lookup returns pre-edge contents (no bypass).
- mispredict is valid in the same cycle the instruction is in EX; the fetch and pipeline logic act on the next edge.
- ex_stall=1: no write, no stat increment, mispredict=0. The instruction resolves in the cycle it is released.

## Structure
- Package `bpu_pkg`: counter state constants SNT/WNT/WT/ST, PC_STEP=4, function for saturating 2-bit update.
- One sub-module `btb_array`: entry storage with async-reset flops, one combinational read port (fetch), one synchronous write port (EX).
- The top level holds the resolution logic and stats counters.

## Test plan
- Reset: rst_n low, then high; if_pc=0x100 → if_pred_taken=0, if_pred_target=0x104, both counts=0.
- Branch at 0x100, taken to 0x80, predicted_bit=0 → mispredict=1, redirect_pc=0x80; next cycle lookup 0x100 → taken, target 0x80; mispred_count=1.
- Same branch not taken, predicted_bit=1 → mispredict=1, redirect_pc=0x104; cnt 10→01, lookup 0x100 → not taken.
- Four taken resolutions at 0x100 → cnt=11; one not-taken → lookup still predicts taken (cnt=10). Alias 0x200 (same index, different tag) → miss, pred 0.
- jalr at 0x40 to 0x3000 → mispredict=1, redirect 0x3000, lookup 0x40 stays miss; jal at 0x50 to 0x900 → subsequent lookup 0x50 predicts 0x900.
- ex_stall=1 with a taken branch → mispredict=0, no table change, counts unchanged; assert rst_n low mid-sequence → table and counts cleared asynchronously.
